// File: rtl/rtc_i2c_sequencer.sv
// rtc_i2c_sequencer
// Drives the i2c_core master on behalf of two requesters: a periodic RTC poll
// (register-pointer write of 0x00, then an N_BYTES read) and a set-time request
// (pointer 0x00 followed by N_BYTES time bytes in one write). A completed read
// is presented as one atomic word on time_data with a one-cycle time_valid.
//
// Ports
//   clk_sys, reset           system clock, synchronous active-high reset
//   poll_tick                one-cycle read request, remembered one deep
//   set_valid/set_ready/     set-time handshake; set_data byte i = [8i+7:8i]
//   set_data                 (i=0 seconds ... i=N_BYTES-1 year)
//   i2c_wr_address/          one-cycle transaction start strobes to the core
//   i2c_rd_address
//   i2c_data_address         constant RTC_ADDR
//   i2c_byte_read            constant N_BYTES
//   i2c_in_valid/in_data     one-cycle transmit byte strobe to the core
//   i2c_in_ready             core ready; rising edges pace the write bytes
//   i2c_out_valid/out_data   core read-byte strobe and data
//   time_valid/time_data     one-cycle pulse with the freshly completed read
//   busy                     high outside IDLE
//   error                    one-cycle pulse when a transaction times out
module rtc_i2c_sequencer #(
  parameter logic [6:0] RTC_ADDR       = 7'h68,
  parameter int         N_BYTES        = 7,
  parameter int         TIMEOUT_CYCLES = 500000,
  parameter int         GAP_CYCLES     = 2000
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic                 poll_tick,
  input  logic                 set_valid,
  input  logic [8*N_BYTES-1:0] set_data,
  output logic                 set_ready,
  output logic                 i2c_wr_address,
  output logic                 i2c_rd_address,
  output logic [6:0]           i2c_data_address,
  output logic [7:0]           i2c_byte_read,
  output logic                 i2c_in_valid,
  output logic [7:0]           i2c_in_data,
  input  logic                 i2c_in_ready,
  input  logic                 i2c_out_valid,
  input  logic [7:0]           i2c_out_data,
  output logic                 time_valid,
  output logic [8*N_BYTES-1:0] time_data,
  output logic                 busy,
  output logic                 error
);

  localparam int W     = 8*N_BYTES;
  // edge counter reaches N_BYTES+2 on the final edge of a set-time write
  localparam int IDX_W = $clog2(N_BYTES+3);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES+1);
  localparam int GAP_W = $clog2(GAP_CYCLES+1);

  localparam logic [IDX_W-1:0] LAST_RD  = IDX_W'(N_BYTES-1);
  localparam logic [IDX_W-1:0] WR_BYTES = IDX_W'(N_BYTES+1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES-1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES-1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PTR_WR = 3'd1,
    RD     = 3'd2,
    WR     = 3'd3,
    GAP    = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic               poll_pending_q, poll_pending_d;
  logic [W-1:0]       set_buf_q, set_buf_d;
  logic [W-1:0]       shadow_q, shadow_d;
  logic [W-1:0]       time_data_q, time_data_d;
  logic [IDX_W-1:0]   rd_idx_q, rd_idx_d;
  logic [IDX_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic               gap_to_rd_q, gap_to_rd_d;
  logic               in_ready_q;
  logic               wr_addr_q, wr_addr_d;
  logic               rd_addr_q, rd_addr_d;
  logic               in_valid_q, in_valid_d;
  logic [7:0]         in_data_q, in_data_d;
  logic               time_valid_q, time_valid_d;
  logic               error_q, error_d;

  logic               in_rdy_rise;
  logic [IDX_W-1:0]   n_tx;
  logic [7:0]         tx_byte;

  assign in_rdy_rise = i2c_in_ready & ~in_ready_q;

  // Bytes in the current write: the pointer alone for a poll, pointer plus
  // all time registers for a set.
  assign n_tx = (state_q == PTR_WR) ? IDX_W'(1) : WR_BYTES;

  // Byte k of a write: k=0 is the register pointer 0x00, k>=1 is time byte k-1.
  // edge_cnt_q equals the number of bytes already sent when an edge arrives.
  always_comb begin
    tx_byte = 8'h00;
    for (int k = 1; k <= N_BYTES; k++)
      if (edge_cnt_q == IDX_W'(k)) tx_byte = set_buf_q[8*(k-1) +: 8];
  end

  always_comb begin
    state_d        = state_q;
    poll_pending_d = poll_pending_q | poll_tick;
    set_buf_d      = set_buf_q;
    shadow_d       = shadow_q;
    time_data_d    = time_data_q;
    rd_idx_d       = rd_idx_q;
    edge_cnt_d     = edge_cnt_q;
    tmo_cnt_d      = tmo_cnt_q;
    gap_cnt_d      = gap_cnt_q;
    gap_to_rd_d    = gap_to_rd_q;
    wr_addr_d      = 1'b0;
    rd_addr_d      = 1'b0;
    in_valid_d     = 1'b0;
    in_data_d      = in_data_q;
    time_valid_d   = 1'b0;
    error_d        = 1'b0;

    case (state_q)
      IDLE: begin
        // A set request wins; a pending poll waits until set_valid drops.
        if (set_valid) begin
          state_d   = WR;
          set_buf_d = set_data;
        end else if (poll_pending_q) begin
          state_d        = PTR_WR;
          poll_pending_d = poll_tick;
        end
        // Either write starts with the address strobe and byte 0 together.
        if (set_valid || poll_pending_q) begin
          wr_addr_d  = 1'b1;
          in_valid_d = 1'b1;
          in_data_d  = 8'h00;
          edge_cnt_d = '0;
          tmo_cnt_d  = '0;
        end
      end

      PTR_WR, WR: begin
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        if (in_rdy_rise) begin
          tmo_cnt_d  = '0;
          edge_cnt_d = edge_cnt_q + IDX_W'(1);
          // The first edge is the address ACK; byte 0 is already latched.
          if (edge_cnt_q != '0) begin
            if (edge_cnt_q < n_tx) begin
              in_valid_d = 1'b1;
              in_data_d  = tx_byte;
            end else begin
              // Withholding in_valid lets the core NACK-terminate and STOP.
              state_d     = GAP;
              gap_cnt_d   = '0;
              gap_to_rd_d = (state_q == PTR_WR);
            end
          end
        end else if (tmo_cnt_q == TMO_LAST) begin
          error_d     = 1'b1;
          state_d     = GAP;
          gap_cnt_d   = '0;
          gap_to_rd_d = 1'b0;
        end
      end

      RD: begin
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        if (i2c_out_valid) begin
          tmo_cnt_d = '0;
          for (int i = 0; i < N_BYTES; i++)
            if (rd_idx_q == IDX_W'(i)) shadow_d[8*i +: 8] = i2c_out_data;
          rd_idx_d = rd_idx_q + IDX_W'(1);
          if (rd_idx_q == LAST_RD) begin
            // Publish the whole word at once so readers never see a mix.
            time_data_d  = shadow_d;
            time_valid_d = 1'b1;
            state_d      = GAP;
            gap_cnt_d    = '0;
            gap_to_rd_d  = 1'b0;
          end
        end else if (tmo_cnt_q == TMO_LAST) begin
          // Partial shadow is dropped: time_data keeps the last good read.
          error_d     = 1'b1;
          state_d     = GAP;
          gap_cnt_d   = '0;
          gap_to_rd_d = 1'b0;
        end
      end

      GAP: begin
        // Gives the core time to finish STOP before the next start strobe.
        if (gap_cnt_q == GAP_LAST) begin
          gap_to_rd_d = 1'b0;
          if (gap_to_rd_q) begin
            state_d   = RD;
            rd_addr_d = 1'b1;
            rd_idx_d  = '0;
            tmo_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q        <= IDLE;
      poll_pending_q <= 1'b0;
      set_buf_q      <= '0;
      shadow_q       <= '0;
      time_data_q    <= '0;
      rd_idx_q       <= '0;
      edge_cnt_q     <= '0;
      tmo_cnt_q      <= '0;
      gap_cnt_q      <= '0;
      gap_to_rd_q    <= 1'b0;
      in_ready_q     <= 1'b0;
      wr_addr_q      <= 1'b0;
      rd_addr_q      <= 1'b0;
      in_valid_q     <= 1'b0;
      in_data_q      <= 8'h00;
      time_valid_q   <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      poll_pending_q <= poll_pending_d;
      set_buf_q      <= set_buf_d;
      shadow_q       <= shadow_d;
      time_data_q    <= time_data_d;
      rd_idx_q       <= rd_idx_d;
      edge_cnt_q     <= edge_cnt_d;
      tmo_cnt_q      <= tmo_cnt_d;
      gap_cnt_q      <= gap_cnt_d;
      gap_to_rd_q    <= gap_to_rd_d;
      in_ready_q     <= i2c_in_ready;
      wr_addr_q      <= wr_addr_d;
      rd_addr_q      <= rd_addr_d;
      in_valid_q     <= in_valid_d;
      in_data_q      <= in_data_d;
      time_valid_q   <= time_valid_d;
      error_q        <= error_d;
    end
  end

  assign set_ready        = (state_q == IDLE);
  assign busy             = (state_q != IDLE);
  assign i2c_wr_address   = wr_addr_q;
  assign i2c_rd_address   = rd_addr_q;
  assign i2c_data_address = RTC_ADDR;
  assign i2c_byte_read    = 8'(N_BYTES);
  assign i2c_in_valid     = in_valid_q;
  assign i2c_in_data      = in_data_q;
  assign time_valid       = time_valid_q;
  assign time_data        = time_data_q;
  assign error            = error_q;

endmodule

// File: tb/tb_rtc_i2c_sequencer.sv
// Bench for rtc_i2c_sequencer: a cycle-level i2c_core stand-in answers the
// sequencer's strobes; expected byte streams, transaction order and time words
// come from the transaction-level rules (pointer 0x00 + data, LSB byte first).
module tb_rtc_i2c_sequencer;
  localparam int NB  = 7;
  localparam int TMO = 300;
  localparam int GAP = 25;

  localparam int C_IDLE = 0, C_WADDR = 1, C_WBYTE = 2, C_WCHK = 3, C_RD = 4;

  logic        clk_sys = 1'b0;
  logic        reset, poll_tick, set_valid, set_ready;
  logic [55:0] set_data, time_data;
  logic        i2c_wr_address, i2c_rd_address, i2c_in_valid, i2c_in_ready;
  logic [6:0]  i2c_data_address;
  logic [7:0]  i2c_byte_read, i2c_in_data, i2c_out_data;
  logic        i2c_out_valid, time_valid, busy, error;

  always #5 clk_sys = ~clk_sys;

  rtc_i2c_sequencer #(.RTC_ADDR(7'h68), .N_BYTES(NB), .TIMEOUT_CYCLES(TMO),
                      .GAP_CYCLES(GAP)) dut (
    .clk_sys(clk_sys), .reset(reset), .poll_tick(poll_tick),
    .set_valid(set_valid), .set_data(set_data), .set_ready(set_ready),
    .i2c_wr_address(i2c_wr_address), .i2c_rd_address(i2c_rd_address),
    .i2c_data_address(i2c_data_address), .i2c_byte_read(i2c_byte_read),
    .i2c_in_valid(i2c_in_valid), .i2c_in_data(i2c_in_data),
    .i2c_in_ready(i2c_in_ready), .i2c_out_valid(i2c_out_valid),
    .i2c_out_data(i2c_out_data), .time_valid(time_valid), .time_data(time_data),
    .busy(busy), .error(error));

  int errors = 0, checks = 0;

  // core stand-in and observation log
  int          ncyc = 0, cst = C_IDLE, ctimer = 0, rcnt = 0, edge_age = 100;
  int          edges = 0, n_wr = 0, n_rd = 0, lat_err = 0, wide_err = 0;
  int          tv_cnt = 0, err_cnt = 0, last_edge_cyc = 0, rd_gap = 0, err_cyc = 0;
  bit          nack = 1'b0;
  logic [7:0]  rd_bytes [NB];
  logic [7:0]  tx_q[$];
  int          seq_q[$], wr_cyc_q[$], fall_q[$];
  logic [55:0] tv_data = '0;
  logic        p_wr = 0, p_rd = 0, p_iv = 0, p_tv = 0, p_er = 0, p_busy = 0;

  initial begin
    i2c_in_ready = 1'b0; i2c_out_valid = 1'b0; i2c_out_data = 8'h00;
    forever begin
      @(negedge clk_sys);
      ncyc++; edge_age++;
      i2c_in_ready = 1'b0; i2c_out_valid = 1'b0;
      if (i2c_in_valid) begin
        tx_q.push_back(i2c_in_data);
        if (!i2c_wr_address && edge_age != 1) lat_err++;
      end
      if (i2c_wr_address) begin n_wr++; seq_q.push_back(1); wr_cyc_q.push_back(ncyc); end
      if (i2c_rd_address) begin n_rd++; seq_q.push_back(2); rd_gap = ncyc - last_edge_cyc; end
      if (time_valid) begin tv_cnt++; tv_data = time_data; end
      if (error) begin err_cnt++; err_cyc = ncyc; end
      if (!busy && p_busy) fall_q.push_back(ncyc);
      if ((i2c_wr_address && p_wr) || (i2c_rd_address && p_rd) || (i2c_in_valid && p_iv) ||
          (time_valid && p_tv) || (error && p_er)) wide_err++;
      p_wr = i2c_wr_address; p_rd = i2c_rd_address; p_iv = i2c_in_valid;
      p_tv = time_valid; p_er = error; p_busy = busy;
      if (reset) cst = C_IDLE;
      else begin
        if (i2c_wr_address) begin cst = C_WADDR; ctimer = 4; end
        if (i2c_rd_address) begin cst = C_RD; ctimer = 5; rcnt = 0; end
        case (cst)
          C_WADDR: begin
            ctimer--;
            if (ctimer == 0) begin
              if (nack) cst = C_IDLE;
              else begin
                i2c_in_ready = 1'b1; edges++; edge_age = 0; last_edge_cyc = ncyc;
                cst = C_WBYTE; ctimer = 6;
              end
            end
          end
          C_WBYTE: begin
            ctimer--;
            if (ctimer == 0) begin
              i2c_in_ready = 1'b1; edges++; edge_age = 0; last_edge_cyc = ncyc;
              cst = C_WCHK; ctimer = 3;
            end
          end
          C_WCHK: begin
            if (i2c_in_valid) begin cst = C_WBYTE; ctimer = 6; end
            else begin ctimer--; if (ctimer == 0) cst = C_IDLE; end
          end
          C_RD: begin
            ctimer--;
            if (ctimer == 0) begin
              i2c_out_valid = 1'b1; i2c_out_data = rd_bytes[rcnt]; rcnt++;
              if (rcnt == NB) cst = C_IDLE; else ctimer = 5;
            end
          end
          default: ;
        endcase
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish got=timeout exp=finish");
    $fatal(1);
  end

  function automatic logic [55:0] pack_time();
    logic [55:0] t = '0;
    for (int i = 0; i < NB; i++) t |= 56'(rd_bytes[i]) << (8*i);
    return t;
  endfunction

  function automatic int seq_code();
    int c = 0;
    foreach (seq_q[i]) c = c*10 + seq_q[i];
    return c;
  endfunction

  task automatic clear_log();
    tx_q.delete(); seq_q.delete(); wr_cyc_q.delete(); fall_q.delete();
    edges = 0; n_wr = 0; n_rd = 0; lat_err = 0; tv_cnt = 0; err_cnt = 0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic randomize_rd();
    for (int i = 0; i < NB; i++) rd_bytes[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic test_reset();
    reset = 1'b1; poll_tick = 1'b0; set_valid = 1'b0; set_data = '0; nack = 1'b0;
    cycles(3);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0h exp=0", busy); end
    checks++; if (set_ready !== 1'b1) begin errors++; $display("FAIL reset_set_ready got=%0h exp=1", set_ready); end
    checks++; if ({i2c_wr_address, i2c_rd_address, i2c_in_valid} !== 3'b000) begin errors++; $display("FAIL reset_strobes got=%b exp=000", {i2c_wr_address, i2c_rd_address, i2c_in_valid}); end
    checks++; if (i2c_in_data !== 8'h00) begin errors++; $display("FAIL reset_in_data got=%0h exp=0", i2c_in_data); end
    checks++; if (time_data !== 56'h0) begin errors++; $display("FAIL reset_time_data got=%0h exp=0", time_data); end
    checks++; if ({time_valid, error} !== 2'b00) begin errors++; $display("FAIL reset_tv_err got=%b exp=00", {time_valid, error}); end
    checks++; if (i2c_data_address !== 7'h68) begin errors++; $display("FAIL slave_addr got=%0h exp=68", i2c_data_address); end
    checks++; if (i2c_byte_read !== 8'd7) begin errors++; $display("FAIL byte_read got=%0d exp=7", i2c_byte_read); end
    reset = 1'b0;
    cycles(2);
  endtask

  task automatic test_poll(input string tag);
    logic [55:0] exp_t;
    exp_t = pack_time();
    clear_log();
    poll_tick = 1'b1; cycles(1); poll_tick = 1'b0;
    cycles(400);
    checks++; if (seq_code() != 12) begin errors++; $display("FAIL %s_order got=%0d exp=12", tag, seq_code()); end
    checks++; if (tx_q.size() != 1 || tx_q[0] !== 8'h00) begin errors++; $display("FAIL %s_ptr_bytes got=%0d bytes exp=1 byte 00", tag, tx_q.size()); end
    checks++; if (edges != 2) begin errors++; $display("FAIL %s_edges got=%0d exp=2", tag, edges); end
    checks++; if (rd_gap != GAP + 1) begin errors++; $display("FAIL %s_gap_to_rd got=%0d exp=%0d", tag, rd_gap, GAP + 1); end
    checks++; if (tv_cnt != 1) begin errors++; $display("FAIL %s_tv_count got=%0d exp=1", tag, tv_cnt); end
    checks++; if (tv_data !== exp_t) begin errors++; $display("FAIL %s_time_word got=%0h exp=%0h", tag, tv_data, exp_t); end
    checks++; if (err_cnt != 0 || busy !== 1'b0) begin errors++; $display("FAIL %s_end_state got=err%0d busy%0h exp=err0 busy0", tag, err_cnt, busy); end
  endtask

  task automatic test_set(input string tag, input logic [55:0] d);
    logic [7:0]  exp_q[$];
    logic [55:0] td;
    exp_q.push_back(8'h00);
    for (int i = 0; i < NB; i++) exp_q.push_back(d[8*i +: 8]);
    td = time_data;
    clear_log();
    checks++; if (set_ready !== 1'b1) begin errors++; $display("FAIL %s_ready_idle got=%0h exp=1", tag, set_ready); end
    set_valid = 1'b1; set_data = d; cycles(1);
    set_valid = 1'b0; set_data = {$urandom, $urandom};
    checks++; if ({busy, set_ready, i2c_wr_address, i2c_in_valid} !== 4'b1011) begin errors++; $display("FAIL %s_start got=%b exp=1011", tag, {busy, set_ready, i2c_wr_address, i2c_in_valid}); end
    cycles(300);
    checks++; if (seq_code() != 1) begin errors++; $display("FAIL %s_order got=%0d exp=1", tag, seq_code()); end
    checks++;
    if (tx_q.size() != exp_q.size()) begin errors++; $display("FAIL %s_byte_count got=%0d exp=%0d", tag, tx_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      checks++; if (tx_q[i] !== exp_q[i]) begin errors++; $display("FAIL %s_byte%0d got=%0h exp=%0h", tag, i, tx_q[i], exp_q[i]); end
    end
    checks++; if (edges != NB + 2) begin errors++; $display("FAIL %s_edges got=%0d exp=%0d", tag, edges, NB + 2); end
    checks++; if (lat_err != 0) begin errors++; $display("FAIL %s_in_valid_latency got=%0d late exp=0", tag, lat_err); end
    checks++; if (fall_q.size() != 1 || fall_q[0] - last_edge_cyc != GAP + 1) begin errors++; $display("FAIL %s_busy_fall got=%0d falls exp=1 at gap %0d", tag, fall_q.size(), GAP + 1); end
    checks++; if (tv_cnt != 0 || time_data !== td) begin errors++; $display("FAIL %s_time_untouched got=%0h exp=%0h", tag, time_data, td); end
  endtask

  task automatic test_set_and_poll();
    logic [55:0] d, exp_t;
    logic [7:0]  exp_q[$];
    randomize_rd(); exp_t = pack_time();
    d = {$urandom, $urandom};
    exp_q.push_back(8'h00);
    for (int i = 0; i < NB; i++) exp_q.push_back(d[8*i +: 8]);
    exp_q.push_back(8'h00);
    clear_log();
    set_valid = 1'b1; set_data = d; poll_tick = 1'b1; cycles(1);
    set_valid = 1'b0; poll_tick = 1'b0;
    cycles(600);
    checks++; if (seq_code() != 112) begin errors++; $display("FAIL same_cycle_order got=%0d exp=112", seq_code()); end
    checks++;
    if (tx_q.size() != exp_q.size()) begin errors++; $display("FAIL same_cycle_bytes got=%0d exp=%0d", tx_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      checks++; if (tx_q[i] !== exp_q[i]) begin errors++; $display("FAIL same_cycle_byte%0d got=%0h exp=%0h", i, tx_q[i], exp_q[i]); end
    end
    checks++; if (wr_cyc_q.size() != 2 || fall_q.size() < 1 || wr_cyc_q[1] - fall_q[0] != 1) begin errors++; $display("FAIL same_cycle_poll_follow got=%0d writes exp=2 one cycle after idle", wr_cyc_q.size()); end
    checks++; if (tv_cnt != 1 || tv_data !== exp_t) begin errors++; $display("FAIL same_cycle_time got=%0h x%0d exp=%0h x1", tv_data, tv_cnt, exp_t); end
  endtask

  task automatic test_nack();
    logic [55:0] td;
    td = time_data;
    nack = 1'b1;
    clear_log();
    poll_tick = 1'b1; cycles(1); poll_tick = 1'b0;
    cycles(TMO + GAP + 100);
    checks++; if (err_cnt != 1) begin errors++; $display("FAIL nack_error_pulses got=%0d exp=1", err_cnt); end
    checks++; if (wr_cyc_q.size() != 1 || err_cyc - wr_cyc_q[0] != TMO) begin errors++; $display("FAIL nack_timeout_cycles got=%0d exp=%0d", err_cyc - (wr_cyc_q.size() > 0 ? wr_cyc_q[0] : 0), TMO); end
    checks++; if (tv_cnt != 0 || time_data !== td) begin errors++; $display("FAIL nack_time_kept got=%0h exp=%0h", time_data, td); end
    checks++; if (n_rd != 0 || n_wr != 1) begin errors++; $display("FAIL nack_no_retry got=wr%0d rd%0d exp=wr1 rd0", n_wr, n_rd); end
    checks++; if (fall_q.size() != 1 || fall_q[0] - err_cyc != GAP) begin errors++; $display("FAIL nack_gap_to_idle got=%0d falls exp=1 after %0d", fall_q.size(), GAP); end
    nack = 1'b0;
  endtask

  task automatic test_ticks_during_set();
    logic [55:0] exp_t;
    randomize_rd(); exp_t = pack_time();
    clear_log();
    set_valid = 1'b1; set_data = {$urandom, $urandom}; cycles(1); set_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycles(8 + $urandom_range(0, 5));
      poll_tick = 1'b1; cycles(1); poll_tick = 1'b0;
    end
    cycles(600);
    checks++; if (seq_code() != 112) begin errors++; $display("FAIL ticks_order got=%0d exp=112", seq_code()); end
    checks++; if (n_rd != 1 || tv_cnt != 1) begin errors++; $display("FAIL ticks_one_poll got=rd%0d tv%0d exp=rd1 tv1", n_rd, tv_cnt); end
    checks++; if (tv_data !== exp_t) begin errors++; $display("FAIL ticks_time got=%0h exp=%0h", tv_data, exp_t); end
  endtask

  task automatic test_reset_mid_read();
    bit found;
    found = 1'b0;
    randomize_rd();
    clear_log();
    poll_tick = 1'b1; cycles(1); poll_tick = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      cycles(1);
      if (rcnt == 4 && i2c_out_valid) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL midread_reach got=timeout exp=4th byte"); end
    reset = 1'b1; cycles(1);
    checks++; if ({busy, set_ready} !== 2'b01) begin errors++; $display("FAIL midread_busy_ready got=%b exp=01", {busy, set_ready}); end
    checks++; if ({i2c_wr_address, i2c_rd_address, i2c_in_valid, time_valid, error} !== 5'b0) begin errors++; $display("FAIL midread_strobes got=%b exp=00000", {i2c_wr_address, i2c_rd_address, i2c_in_valid, time_valid, error}); end
    checks++; if (time_data !== 56'h0 || i2c_in_data !== 8'h00) begin errors++; $display("FAIL midread_data got=%0h/%0h exp=0/0", time_data, i2c_in_data); end
    cycles(2); reset = 1'b0;
    cycles(200);
    checks++; if (tv_cnt != 0 || busy !== 1'b0 || n_rd != 1) begin errors++; $display("FAIL midread_after got=tv%0d busy%0h rd%0d exp=tv0 busy0 rd1", tv_cnt, busy, n_rd); end
  endtask

  initial begin
    test_reset();
    rd_bytes = '{8'h30, 8'h59, 8'h23, 8'h04, 8'h15, 8'h06, 8'h21};
    test_poll("poll_fixed");
    checks++; if (tv_data !== 56'h21_06_15_04_23_59_30) begin errors++; $display("FAIL poll_fixed_word got=%0h exp=21061504235930", tv_data); end
    test_set("set_fixed", 56'h22_01_01_06_12_00_00);
    for (int r = 0; r < 3; r++) begin
      randomize_rd();
      test_poll($sformatf("poll_rand%0d", r));
      test_set($sformatf("set_rand%0d", r), {$urandom, $urandom});
    end
    test_set_and_poll();
    test_nack();
    test_ticks_during_set();
    test_reset_mid_read();
    checks++; if (wide_err != 0) begin errors++; $display("FAIL strobe_width got=%0d wide exp=0", wide_err); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
